// File: rtl/ctrl_pkg.sv
// Shared definitions for the datapath control unit: opcodes, RTYPE func bit
// positions, ALU operation codes, FSM states and the decoded control vector.
package ctrl_pkg;

    localparam logic [3:0] OP_LOAD    = 4'b0000;
    localparam logic [3:0] OP_STORE   = 4'b0001;
    localparam logic [3:0] OP_JUMP    = 4'b0010;
    localparam logic [3:0] OP_HALT    = 4'b0011;
    localparam logic [3:0] OP_BRANCHZ = 4'b0100;
    localparam logic [3:0] OP_RTYPE   = 4'b1000;
    localparam logic [3:0] OP_WND     = 4'b1001;
    localparam logic [3:0] OP_ADDI    = 4'b1100;
    localparam logic [3:0] OP_SUBI    = 4'b1101;
    localparam logic [3:0] OP_ANDI    = 4'b1110;
    localparam logic [3:0] OP_ORI     = 4'b1111;

    localparam int F_MOV  = 0;
    localparam int F_ADD  = 1;
    localparam int F_SUB  = 2;
    localparam int F_AND  = 3;
    localparam int F_OR   = 4;
    localparam int F_NOT  = 5;
    localparam int F_RSVD = 6;
    localparam int F_NOP  = 7;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_NOT   = 3'd4;
    localparam logic [2:0] ALU_PASS1 = 3'd5;
    localparam logic [2:0] ALU_PASS2 = 3'd6;

    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_RUN     = 2'd1,
        S_MEMWAIT = 2'd2,
        S_HALT    = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic       pc_sel;
        logic       branch_sel;
        logic       jump_sel;
        logic       reg_sel;
        logic       in_sel;
        logic       sel_dm;
        logic       sel_alu;
        logic       reg_write;
        logic       nop;
        logic       ld_wnd;
        logic       mem_write;
        logic       mem_read;
        logic [1:0] wnd_ctrl;
        logic [2:0] func_ctrl;
    } ctrl_t;

    // Idle vector (reset / halt): everything low, nop high.
    localparam ctrl_t CTRL_IDLE = '{nop: 1'b1, default: '0};
    // Decode baseline: sequential PC, not a NOP.
    localparam ctrl_t CTRL_BASE = '{nop: 1'b1, pc_sel: 1'b1, default: '0};

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational instruction decoder: opcode/func -> control vector plus
// illegal, halt and memory-access flags. Illegal encodings yield the baseline vector.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] i_inst,
    input  logic [7:0] i_func,
    output ctrl_t      o_ctrl,
    output logic       o_illegal,
    output logic       o_halt,
    output logic       o_mem
);

    logic w_onehot;

    assign w_onehot = (i_func != 8'd0) && ((i_func & (i_func - 8'd1)) == 8'd0);

    always_comb begin
        o_ctrl    = CTRL_BASE;
        o_illegal = 1'b0;
        o_halt    = 1'b0;
        o_mem     = 1'b0;
        case (i_inst)
            OP_LOAD: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.sel_dm    = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_mem            = 1'b1;
            end
            OP_STORE: begin
                o_ctrl.mem_write = 1'b1;
                o_mem            = 1'b1;
            end
            OP_JUMP: begin
                o_ctrl.jump_sel = 1'b1;
                o_ctrl.pc_sel   = 1'b0;
            end
            OP_HALT: begin
                o_halt = 1'b1;
            end
            OP_BRANCHZ: begin
                o_ctrl.branch_sel = 1'b1;
                o_ctrl.reg_sel    = 1'b1;
                o_ctrl.func_ctrl  = ALU_SUB;
            end
            OP_RTYPE: begin
                if (!w_onehot || i_func[F_RSVD]) begin
                    o_illegal = 1'b1;
                end else begin
                    o_ctrl.reg_sel   = 1'b1;
                    o_ctrl.sel_alu   = 1'b1;
                    o_ctrl.reg_write = 1'b1;
                    if (i_func[F_MOV])      o_ctrl.func_ctrl = ALU_PASS2;
                    else if (i_func[F_ADD]) o_ctrl.func_ctrl = ALU_ADD;
                    else if (i_func[F_SUB]) o_ctrl.func_ctrl = ALU_SUB;
                    else if (i_func[F_AND]) o_ctrl.func_ctrl = ALU_AND;
                    else if (i_func[F_OR])  o_ctrl.func_ctrl = ALU_OR;
                    else if (i_func[F_NOT]) o_ctrl.func_ctrl = ALU_NOT;
                    else begin
                        // Only the NOP bit remains: keep the ALU path, drop the write.
                        o_ctrl.nop       = 1'b0;
                        o_ctrl.reg_write = 1'b0;
                    end
                end
            end
            OP_WND: begin
                o_ctrl.ld_wnd   = 1'b1;
                o_ctrl.wnd_ctrl = i_func[1:0];
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
                o_ctrl.in_sel    = 1'b1;
                o_ctrl.sel_alu   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                case (i_inst[1:0])
                    2'b00:   o_ctrl.func_ctrl = ALU_ADD;
                    2'b01:   o_ctrl.func_ctrl = ALU_SUB;
                    2'b10:   o_ctrl.func_ctrl = ALU_AND;
                    default: o_ctrl.func_ctrl = ALU_OR;
                endcase
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dp_ctrl_fsm.sv
// Control unit FSM (RESET/RUN/MEMWAIT/HALT) with write gating and sticky flags.
// Define CTRL_RETIRE_CNT_EN to add the 16-bit retired-instruction counter output.
module dp_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int MEM_LAT    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] inst,
    input  logic [7:0] func,
    input  logic       run_en,
    output logic       rstPC,
    output logic       ldPC,
    output logic       pcSel,
    output logic       branchSel,
    output logic       jumpSel,
    output logic       regSel,
    output logic       inSel,
    output logic       selDm,
    output logic       selALU,
    output logic       regWrite,
    output logic       nop,
    output logic       ldWnd,
    output logic       memWrite,
    output logic       memRead,
    output logic [1:0] wndCtrl,
    output logic [2:0] funcCtrl,
    output logic       halted,
    output logic       illegal,
`ifdef CTRL_RETIRE_CNT_EN
    output logic [15:0] retired,
`endif
    output logic [1:0] dbg_state
);

    localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);
    localparam logic [3:0] MEM_LAST = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;
    localparam logic       MEM_STALL = (MEM_LAT > 0);

    ctrl_state_t r_state;
    ctrl_state_t w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    ctrl_t       r_held;
    logic        r_halted;
    logic        r_illegal;

    ctrl_t       w_dec;
    logic        w_dec_illegal;
    logic        w_dec_halt;
    logic        w_dec_mem;

    ctrl_t       w_out;
    logic        w_ld_pc;
    logic        w_rst_pc;
    logic        w_capture;
    logic        w_set_halt;
    logic        w_set_illegal;

    ctrl_decode u_decode (
        .i_inst    (inst),
        .i_func    (func),
        .o_ctrl    (w_dec),
        .o_illegal (w_dec_illegal),
        .o_halt    (w_dec_halt),
        .o_mem     (w_dec_mem)
    );

    always_comb begin
        w_next        = r_state;
        w_cnt_next    = r_cnt;
        w_out         = CTRL_IDLE;
        w_ld_pc       = 1'b0;
        w_rst_pc      = 1'b0;
        w_capture     = 1'b0;
        w_set_halt    = 1'b0;
        w_set_illegal = 1'b0;
        case (r_state)
            S_RESET: begin
                w_rst_pc = 1'b1;
                if (r_cnt == RST_LAST) begin
                    w_next     = S_RUN;
                    w_cnt_next = 4'd0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            S_RUN: begin
                w_out = w_dec;
                if (!run_en) begin
                    w_out.reg_write = 1'b0;
                    w_out.mem_write = 1'b0;
                    w_out.ld_wnd    = 1'b0;
                end else if (w_dec_illegal || w_dec_halt) begin
                    // The stopping instruction itself commits nothing.
                    w_out.reg_write = 1'b0;
                    w_out.mem_write = 1'b0;
                    w_out.ld_wnd    = 1'b0;
                    w_next          = S_HALT;
                    w_set_halt      = 1'b1;
                    w_set_illegal   = w_dec_illegal;
                end else if (w_dec_mem && MEM_STALL) begin
                    w_out.reg_write = 1'b0;
                    w_out.mem_write = 1'b0;
                    w_next          = S_MEMWAIT;
                    w_cnt_next      = MEM_LAST;
                    w_capture       = 1'b1;
                end else begin
                    w_ld_pc = 1'b1;
                end
            end
            S_MEMWAIT: begin
                // Replay the captured vector; its write enable fires on the last cycle only.
                w_out = r_held;
                if (r_cnt == 4'd0) begin
                    w_ld_pc = 1'b1;
                    w_next  = S_RUN;
                end else begin
                    w_out.reg_write = 1'b0;
                    w_out.mem_write = 1'b0;
                    w_cnt_next      = r_cnt - 4'd1;
                end
            end
            default: begin
                w_out = CTRL_IDLE;
            end
        endcase
        if (rst) begin
            w_out    = CTRL_IDLE;
            w_rst_pc = 1'b1;
            w_ld_pc  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_RESET;
            r_cnt     <= 4'd0;
            r_held    <= CTRL_IDLE;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_capture) r_held <= w_dec;
            if (w_set_halt) r_halted <= 1'b1;
            if (w_set_illegal) r_illegal <= 1'b1;
        end
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic [15:0] r_retired;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= 16'd0;
        end else if (w_ld_pc && (r_state != S_RESET)) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign retired = r_retired;
`endif

    assign rstPC     = w_rst_pc;
    assign ldPC      = w_ld_pc;
    assign pcSel     = w_out.pc_sel;
    assign branchSel = w_out.branch_sel;
    assign jumpSel   = w_out.jump_sel;
    assign regSel    = w_out.reg_sel;
    assign inSel     = w_out.in_sel;
    assign selDm     = w_out.sel_dm;
    assign selALU    = w_out.sel_alu;
    assign regWrite  = w_out.reg_write;
    assign nop       = w_out.nop;
    assign ldWnd     = w_out.ld_wnd;
    assign memWrite  = w_out.mem_write;
    assign memRead   = w_out.mem_read;
    assign wndCtrl   = w_out.wnd_ctrl;
    assign funcCtrl  = w_out.func_ctrl;
    assign halted    = r_halted;
    assign illegal   = r_illegal;
    assign dbg_state = r_state;

endmodule

// File: doc/dp_ctrl_fsm.md
Name: dp_ctrl_fsm

Overview:
- Control unit driving the single-cycle datapath's control inputs.
- Decodes the 4-bit opcode and 8-bit function field returned by the datapath.
- Sequences reset, run, memory-wait and halt states; stalls the PC for multi-cycle memory access.
- Stops on HALT or on an illegal encoding.

Parameters:
- RST_CYCLES, 2: cycles rstPC is held after reset release (1..15).
- MEM_LAT, 1: extra wait cycles for LOAD/STORE (0..15); 0 = no stall.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- inst  in  4  opcode, instruction bits [15:12].
- func  in  8  function/immediate field, instruction bits [7:0].
- run_en  in  1  1 = execute; 0 = freeze (no PC load, no writes).
- rstPC, ldPC, pcSel, branchSel, jumpSel  out  1 each  PC control.
- regSel, inSel  out  1 each  ALU op1 select (register / zero-extended immediate).
- selDm, selALU  out  1 each  writeback select (memory / ALU).
- regWrite, nop, ldWnd, memWrite, memRead  out  1 each.
  - nop is a write qualifier: 1 = not a NOP.
- wndCtrl  out  2  new register-window value.
- funcCtrl  out  3  ALU operation.
- halted  out  1  sticky; set in HALT.
- illegal  out  1  sticky; set on an illegal encoding.

Behaviour:
- Reset values: all outputs 0, except rstPC=1 and nop=1.
- rst taken at any cycle, including mid-MEMWAIT, returns the FSM to RESET and clears both counters and both sticky flags.
- States and transitions:
  - RESET: rstPC=1, ldPC=0. Counts RST_CYCLES, then goes to RUN.
  - RUN, run_en=0: ldPC, regWrite, memWrite, ldWnd all 0.
  - RUN, run_en=1: decode one instruction per cycle, ldPC=1.
  - RUN, LOAD or STORE with MEM_LAT>0: go to MEMWAIT.
  - RUN, HALT opcode or illegal encoding: go to HALT.
  - MEMWAIT: control vector held stable; ldPC=0, regWrite=0, memWrite=0 while the counter runs.
  - MEMWAIT, final cycle: ldPC=1; regWrite=1 (LOAD) or memWrite=1 (STORE); return to RUN. run_en is ignored here.
  - HALT: all enables 0, halted=1. Exits only via rst.
- Default decode outputs: 0, except nop=1 and pcSel=1 (sequential PC) for every non-JUMP opcode.
- Opcode decode:
  - 0000 LOAD: memRead, selDm, regWrite.
  - 0001 STORE: memWrite, memRead=0.
  - 0010 JUMP: jumpSel=1, pcSel=0.
  - 0011 HALT.
  - 0100 BRANCHZ: branchSel, regSel, funcCtrl=SUB.
  - 1000 RTYPE: regSel, selALU, regWrite. func must be exactly one-hot:
    - bit0 MOV (funcCtrl=PASS2).
    - bits1..5: ADD, SUB, AND, OR, NOT.
    - bit7 NOP: nop=0, regWrite=0.
    - bit6 or a non-one-hot func is illegal.
  - 1001 WND: ldWnd=1, wndCtrl=func[1:0].
  - 1100/1101/1110/1111 ADDI/SUBI/ANDI/ORI: inSel, selALU, regWrite, matching funcCtrl.
  - Any other opcode is illegal: set illegal, go to HALT. The illegal instruction's writes are suppressed in that same cycle.
- Exclusivity guarantees:
  - At most one of jumpSel or branchSel is asserted.
  - selDm and selALU are never both 1.
  - regSel and inSel are never both 1.
- Control outputs are combinational from state plus inst/func; state, counters and flags are registered.

Optional Feature:
- CTRL_RETIRE_CNT_EN defined:
  - Adds output retired[15:0].
  - Increments on every cycle with ldPC=1 outside RESET.
  - Wraps 0xFFFF -> 0. Cleared by rst.
- Undefined: no port, no counter logic.

Decomposition:
- Package ctrl_pkg:
  - Opcode constants and RTYPE func bit indices.
  - ALU codes: ADD=0, SUB=1, AND=2, OR=3, NOT=4, PASS1=5, PASS2=6.
  - FSM state enum: RESET, RUN, MEMWAIT, HALT.
- Sub-module ctrl_decode: purely combinational inst/func -> control vector plus illegal/halt/mem flags.
- Top level holds the FSM, counters, sticky flags and output gating.

Test Plan:
- Reset, RST_CYCLES=2: rst high 3 cycles then low -> rstPC=1 for exactly 2 further cycles; ldPC=1 first in cycle 3.
- inst=1100, func=0x05, run_en=1 -> inSel=1, selALU=1, regWrite=1, funcCtrl=0, pcSel=1, ldPC=1 in the same cycle.
- LOAD with MEM_LAT=2 -> memRead=1 for 3 cycles; ldPC and regWrite 0,0,1; back in RUN on cycle 4.
- inst=1000, func=0x80 -> nop=0, regWrite=0, ldPC=1. func=0x06 -> illegal=1, halted=1 next cycle; all enables stay 0 until rst.
- JUMP -> jumpSel=1, pcSel=0. BRANCHZ -> branchSel=1, funcCtrl=1, regSel=1. WND func=0x02 -> ldWnd=1, wndCtrl=2.
- rst asserted in 2nd MEMWAIT cycle of a STORE -> memWrite never 1; FSM in RESET next cycle; retired=0 with CTRL_RETIRE_CNT_EN.
